// File: rtl/crc8_frame_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : crc8_ctrl_pkg
// Brief   : Shared types and constants for the crc8 frame sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package crc8_ctrl_pkg;

  // Bits serialised per byte; fixed by the byte-wide input interface.
  localparam int BITS_PER_BYTE = 8;

  // Width of the in-byte bit counter (indexes 0..BITS_PER_BYTE-1).
  localparam int BIT_CNT_W = 3;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CLEAR     = 3'd1,
    ST_WAIT_BYTE = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage : crc8_ctrl_pkg
`default_nettype wire

// File: rtl/crc8_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : crc8_frame_ctrl_if
// Brief     : Valid/ready byte stream feeding the crc8 frame sequencer.
// Rev       : 1.0  initial release
// ============================================================================
interface crc8_frame_ctrl_if;

  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  // Byte source side.
  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  // Sequencer side.
  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );

endinterface : crc8_frame_ctrl_if
`default_nettype wire

// File: rtl/crc8_frame_ctrl_serializer.sv
`default_nettype none
// ============================================================================
// Module : crc8_byte_serializer
// Brief  : Holds one byte and presents it LSB-first, one bit per shift.
// Rev    : 1.0  initial release
// ============================================================================
module crc8_byte_serializer
  import crc8_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_shift,
  output logic       o_bit,
  output logic       o_last_bit
);

  logic [BITS_PER_BYTE-1:0] r_sreg;
  logic [BIT_CNT_W-1:0]     r_bit_cnt;

  // Load a new byte with the index at bit 0; advance the index on each shift.
  // The index wraps to 0 after the last bit, ready for the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (i_load) begin
      r_sreg    <= i_data;
      r_bit_cnt <= '0;
    end else if (i_shift) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  assign o_bit      = r_sreg[r_bit_cnt];
  assign o_last_bit = (r_bit_cnt == BIT_CNT_W'(BITS_PER_BYTE - 1));

endmodule : crc8_byte_serializer
`default_nettype wire

// File: rtl/crc8_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : crc8_frame_ctrl
// Brief  : Frame sequencer for an external bit-serial crc8 engine. Clears the
//          engine, serialises N bytes LSB-first, then captures the result.
// Rev    : 1.0  initial release
// ============================================================================
module crc8_frame_ctrl
  import crc8_ctrl_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic             i_abort,
  crc8_frame_ctrl_if.slave byte_if,
  output logic             o_crc_clr,
  output logic             o_crc_bit,
  output logic             o_crc_shift,
  input  logic [7:0]       i_crc_result,
  output logic             o_busy,
  output logic             o_done,
  output logic [7:0]       o_crc_out,
  output logic             o_err
);

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic             r_byte_ready;
  logic             r_crc_clr;
  logic             r_crc_shift;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_crc_out;
  logic             r_err;

  logic w_handshake;
  logic w_load;
  logic w_ser_bit;
  logic w_last_bit;

  // Ready is only ever high in WAIT_BYTE, so the handshake implies that state.
  // An abort in the same cycle drops the byte.
  assign w_handshake = byte_if.byte_valid & r_byte_ready;
  assign w_load      = w_handshake & ~i_abort;

  crc8_byte_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_load),
    .i_data     (byte_if.byte_in),
    .i_shift    (r_state == ST_SHIFT),
    .o_bit      (w_ser_bit),
    .o_last_bit (w_last_bit)
  );

  // Sequencer: outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_byte_ready <= 1'b0;
      r_crc_clr    <= 1'b0;
      r_crc_shift  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_crc_out    <= 8'h00;
      r_err        <= 1'b0;
    end else begin
      r_crc_clr <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      if (i_abort && (r_state != ST_IDLE)) begin
        // Abort wins over every transition; the engine is cleared on the way out.
        r_state      <= ST_IDLE;
        r_crc_clr    <= 1'b1;
        r_byte_ready <= 1'b0;
        r_crc_shift  <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              if (i_frame_len != '0) begin
                r_remaining <= i_frame_len;
                r_state     <= ST_CLEAR;
                r_crc_clr   <= 1'b1;
                r_busy      <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end
          ST_CLEAR: begin
            r_state      <= ST_WAIT_BYTE;
            r_byte_ready <= 1'b1;
          end
          ST_WAIT_BYTE: begin
            if (w_handshake) begin
              r_state      <= ST_SHIFT;
              r_byte_ready <= 1'b0;
              r_crc_shift  <= 1'b1;
            end
          end
          ST_SHIFT: begin
            if (w_last_bit) begin
              r_remaining <= r_remaining - 1'b1;
              r_crc_shift <= 1'b0;
              if (r_remaining == LEN_W'(1)) begin
                r_state <= ST_SETTLE;
              end else begin
                r_state      <= ST_WAIT_BYTE;
                r_byte_ready <= 1'b1;
              end
            end
          end
          ST_SETTLE: begin
            // Engine result reflects the final shift by now; capture it so
            // crc_out and done appear together.
            r_state   <= ST_DONE;
            r_crc_out <= i_crc_result;
            r_done    <= 1'b1;
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state      <= ST_IDLE;
            r_byte_ready <= 1'b0;
            r_crc_shift  <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign byte_if.byte_ready = r_byte_ready;
  assign o_crc_clr          = r_crc_clr;
  assign o_crc_shift        = r_crc_shift;
  // Gate the data bit so it reads 0 whenever no shift is in progress.
  assign o_crc_bit          = r_crc_shift & w_ser_bit;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_crc_out          = r_crc_out;
  assign o_err              = r_err;

endmodule : crc8_frame_ctrl
`default_nettype wire

// File: tb/tb_crc8_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_crc8_frame_ctrl
// Brief  : Directed self-checking bench for crc8_frame_ctrl with a crc8
//          engine model (poly 0x07, MSB feedback) wired to its serial port.
// Rev    : 1.0  initial release
// ============================================================================
module tb_crc8_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] frame_len = 8'd0;
  logic       abort = 1'b0;
  logic       crc_clr, crc_bit, crc_shift, busy, done, err;
  logic [7:0] crc_out;
  logic [7:0] r_eng;

  crc8_frame_ctrl_if bus ();

  crc8_frame_ctrl #(.LEN_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (start),
    .i_frame_len  (frame_len),
    .i_abort      (abort),
    .byte_if      (bus),
    .o_crc_clr    (crc_clr),
    .o_crc_bit    (crc_bit),
    .o_crc_shift  (crc_shift),
    .i_crc_result (r_eng),
    .o_busy       (busy),
    .o_done       (done),
    .o_crc_out    (crc_out),
    .o_err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = b ^ c[7];
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] crc_bytes(input logic [7:0] b0, input logic [7:0] b1,
                                           input logic [7:0] b2, input int n);
    logic [7:0] c;
    logic [7:0] bb [3];
    c = 8'h00;
    bb[0] = b0; bb[1] = b1; bb[2] = b2;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < 8; i++) c = crc_step(c, bb[k][i]);
    return c;
  endfunction

  // External engine stand-in.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_eng <= 8'h00;
    else if (crc_clr)   r_eng <= 8'h00;
    else if (crc_shift) r_eng <= crc_step(r_eng, crc_bit);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled just after each rising edge.
  int   shift_cnt, clr_cnt, done_cnt, err_cnt, rdy_viol, bit_viol;
  int   clr_cyc, done_cyc, start_cyc;
  logic bits_q[$];
  always begin
    @(posedge clk);
    #1;
    if (crc_shift) begin
      shift_cnt++;
      bits_q.push_back(crc_bit);
    end
    if (!crc_shift && crc_bit) bit_viol++;
    if (crc_shift && bus.byte_ready) rdy_viol++;
    if (crc_clr) begin clr_cnt++; clr_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    shift_cnt = 0; clr_cnt = 0; done_cnt = 0; err_cnt = 0;
    rdy_viol = 0; bit_viol = 0; clr_cyc = 0; done_cyc = 0;
    bits_q.delete();
  endtask

  task automatic do_start(input logic [7:0] len);
    @(negedge clk);
    start = 1'b1; frame_len = len; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.byte_ready && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) check_eq("ready_timeout", 32'(n), 32'd0);
  endtask

  // Offer one byte after 'dly' cycles of ready; returns in the first SHIFT cycle.
  task automatic send_byte(input logic [7:0] d, input int dly);
    wait_ready();
    repeat (dly) @(negedge clk);
    bus.byte_valid = 1'b1; bus.byte_in = d;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 60) begin @(negedge clk); n++; end
    if (n >= 60) check_eq("done_timeout", 32'(n), 32'd0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pack_bits();
    logic [31:0] v = '0;
    for (int i = 0; i < bits_q.size() && i < 32; i++) v[i] = bits_q[i];
    return v;
  endfunction

  logic [7:0] exp_2d, exp_multi, exp_two;

  initial begin
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
    exp_2d    = crc_bytes(8'h2D, 8'h00, 8'h00, 1);
    exp_multi = crc_bytes(8'hA5, 8'h00, 8'hFF, 3);
    exp_two   = crc_bytes(8'h3C, 8'hC3, 8'h00, 2);

    // Reset / idle
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_crc_out", crc_out, 8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_outs", {bus.byte_ready, crc_clr, crc_bit, crc_shift, busy, done, err}, 7'b0);
    check_eq("idle_crc_out", crc_out, 8'h00);

    // Single byte 0x2D, valid as soon as ready
    clear_mon();
    do_start(8'd1);
    send_byte(8'h2D, 0);
    wait_done();
    check_eq("single_clr_cyc", 32'(clr_cyc - start_cyc), 32'd1);
    check_eq("single_shifts", 32'(shift_cnt), 32'd8);
    check_eq("single_bits", pack_bits(), 32'h0000_002D);
    check_eq("single_latency", 32'(done_cyc - start_cyc), 32'd12);
    check_eq("single_crc", crc_out, exp_2d);
    check_eq("single_done_cnt", 32'(done_cnt), 32'd1);

    // Multi-byte with stalls
    clear_mon();
    do_start(8'd3);
    send_byte(8'hA5, 0);
    send_byte(8'h00, 3);
    send_byte(8'hFF, 1);
    wait_done();
    repeat (5) @(negedge clk);
    check_eq("multi_shifts", 32'(shift_cnt), 32'd24);
    check_eq("multi_bits", pack_bits(), 32'h00FF_00A5);
    check_eq("multi_rdy_in_shift", 32'(rdy_viol), 32'd0);
    check_eq("multi_bit_gating", 32'(bit_viol), 32'd0);
    check_eq("multi_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("multi_crc", crc_out, exp_multi);

    // Zero length
    clear_mon();
    @(negedge clk);
    start = 1'b1; frame_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check_eq("zero_err", err, 1'b1);
    check_eq("zero_busy", busy, 1'b0);
    @(negedge clk);
    check_eq("zero_err_pulse", err, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("zero_counts", {clr_cnt[7:0], done_cnt[7:0], err_cnt[7:0]}, {8'd0, 8'd0, 8'd1});

    // Abort in the 4th SHIFT cycle of byte 1
    clear_mon();
    do_start(8'd2);
    send_byte(8'h77, 0);
    repeat (3) @(negedge clk);
    check_eq("abort_in_shift", crc_shift, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_state", {busy, crc_clr, crc_shift, done}, 4'b0100);
    repeat (6) @(negedge clk);
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    check_eq("abort_crc_kept", crc_out, exp_multi);
    clear_mon();
    do_start(8'd1);
    send_byte(8'h2D, 0);
    wait_done();
    check_eq("post_abort_crc", crc_out, exp_2d);

    // Async reset during WAIT_BYTE of byte 2
    do_start(8'd3);
    send_byte(8'h11, 0);
    wait_ready();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_outs", {bus.byte_ready, busy, crc_shift, crc_clr, done}, 5'b0);
    check_eq("arst_crc_out", crc_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // start pulse during SHIFT is ignored
    clear_mon();
    do_start(8'd2);
    send_byte(8'h3C, 0);
    start = 1'b1; frame_len = 8'd5;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'hC3, 2);
    wait_done();
    repeat (30) @(negedge clk);
    check_eq("ign_start_shifts", 32'(shift_cnt), 32'd16);
    check_eq("ign_start_done", 32'(done_cnt), 32'd1);
    check_eq("ign_start_crc", crc_out, exp_two);
    check_eq("ign_start_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_crc8_frame_ctrl
`default_nettype wire
